// File: rtl/tdc_report_scheduler.sv
// -----------------------------------------------------------------------------
// tdc_report_scheduler
//
// Frames TDC interval results and periodic heartbeat/status records into
// fixed 7-byte checksummed packets and feeds them one byte at a time to the
// UART serializer. Heartbeats win arbitration over measurements. A single
// holding register decouples the measurement stream from the serializer, and
// results that find it occupied are counted as drops.
//
// Parameters
//   HB_PERIOD  clk_100m cycles between heartbeat requests (>= 16)
//   SYNC_BYTE  first byte of every packet
//
// Ports
//   clk_100m      in   1  100 MHz clock, the only clock
//   rst           in   1  synchronous, active-high reset
//   meas_valid    in   1  pulse: new interval result on meas_data
//   meas_data     in  32  interval in clk_100m cycles
//   status_flags  in   8  status snapshot for heartbeat packets
//   tx_data       out  8  byte to serializer
//   tx_valid      out  1  tx_data is valid
//   tx_ready      in   1  serializer accepts on tx_valid & tx_ready
//   drop_count    out 16  measurements lost to backpressure (saturating)
//   busy          out  1  packet in flight
//
// Packet layout (bytes 0..6):
//   measurement: SYNC, 01, d[31:24], d[23:16], d[15:8], d[7:0], CHK
//   heartbeat  : SYNC, 02, seq, status_flags, drop[15:8], drop[7:0], CHK
//   CHK = XOR of bytes 1..5
// -----------------------------------------------------------------------------
module tdc_report_scheduler #(
  parameter int unsigned HB_PERIOD = 100_000_000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        meas_valid,
  input  logic [31:0] meas_data,
  input  logic [7:0]  status_flags,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int          DATA_W = 32;
  localparam int          TW     = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [TW-1:0] HB_TC = TW'(HB_PERIOD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  function automatic logic [7:0] pkt_chk(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [7:0] b4,
                                         input logic [7:0] b5);
    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control state
  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_idx;
  logic               r_hold_full;
  logic               r_hb_pending;
  logic [TW-1:0]      r_timer;
  logic [7:0]         r_seq;
  logic [15:0]        r_drop_count;

  // Datapath state (not reset: only meaningful when qualified by control)
  logic [DATA_W-1:0]  r_hold_data;
  logic [7:0]         r_buf [7];

  logic               w_load_hb;
  logic               w_load_meas;
  logic               w_capture;
  logic               w_drop;
  logic               w_tc;
  logic [7:0]         w_pkt [7];

  // ---------------------------------------------------------------------------
  // Arbitration / next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load_hb   = 1'b0;
    w_load_meas = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hb_pending) begin
          w_load_hb   = 1'b1;
          w_state_nxt = S_SEND;
        end else if (r_hold_full) begin
          w_load_meas = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready && (r_idx == 3'd6)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A result may be captured in the same cycle the entry is unloaded, so a
  // back-to-back arrival is kept rather than dropped.
  assign w_capture = meas_valid && (!r_hold_full || w_load_meas);
  assign w_drop    = meas_valid && !w_capture;
  assign w_tc      = (r_timer == HB_TC);

  // ---------------------------------------------------------------------------
  // Holding register, drop counter, heartbeat timer, sequence number
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_hold_full  <= 1'b0;
      r_drop_count <= 16'h0000;
      r_timer      <= '0;
      r_hb_pending <= 1'b0;
      r_seq        <= 8'h00;
    end else begin
      if (w_capture) begin
        r_hold_full <= 1'b1;
      end else if (w_load_meas) begin
        r_hold_full <= 1'b0;
      end

      if (w_drop) begin
        r_drop_count <= sat_inc16(r_drop_count);
      end

      r_timer <= w_tc ? '0 : r_timer + TW'(1);

      // A terminal count coinciding with a heartbeat load re-arms the
      // request instead of being absorbed by the clear.
      if (w_tc) begin
        r_hb_pending <= 1'b1;
      end else if (w_load_hb) begin
        r_hb_pending <= 1'b0;
      end

      if (w_load_hb) begin
        r_seq <= r_seq + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (w_capture) begin
      r_hold_data <= meas_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet assembly: snapshot all seven bytes at load
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pkt[0] = SYNC_BYTE;
    if (r_hb_pending) begin
      w_pkt[1] = 8'h02;
      w_pkt[2] = r_seq;
      w_pkt[3] = status_flags;
      w_pkt[4] = r_drop_count[15:8];
      w_pkt[5] = r_drop_count[7:0];
    end else begin
      w_pkt[1] = 8'h01;
      w_pkt[2] = r_hold_data[31:24];
      w_pkt[3] = r_hold_data[23:16];
      w_pkt[4] = r_hold_data[15:8];
      w_pkt[5] = r_hold_data[7:0];
    end
    w_pkt[6] = pkt_chk(w_pkt[1], w_pkt[2], w_pkt[3], w_pkt[4], w_pkt[5]);
  end

  always_ff @(posedge clk_100m) begin
    if (w_load_hb || w_load_meas) begin
      r_buf <= w_pkt;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_idx <= 3'd0;
    end else if (w_load_hb || w_load_meas) begin
      r_idx <= 3'd0;
    end else if ((r_state == S_SEND) && tx_ready) begin
      r_idx <= (r_idx == 3'd6) ? 3'd0 : r_idx + 3'd1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (r_state == S_SEND) begin
      case (r_idx)
        3'd0:    tx_data = r_buf[0];
        3'd1:    tx_data = r_buf[1];
        3'd2:    tx_data = r_buf[2];
        3'd3:    tx_data = r_buf[3];
        3'd4:    tx_data = r_buf[4];
        3'd5:    tx_data = r_buf[5];
        3'd6:    tx_data = r_buf[6];
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid   = (r_state == S_SEND);
  assign busy       = (r_state == S_SEND);
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_tdc_report_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tdc_report_scheduler
//
// Directed bench for tdc_report_scheduler with HB_PERIOD=1000. Inputs are
// driven and outputs sampled on the falling edge of clk_100m.
// -----------------------------------------------------------------------------
module tb_tdc_report_scheduler;

  logic        clk_100m = 1'b0;
  logic        rst;
  logic        meas_valid;
  logic [31:0] meas_data;
  logic [7:0]  status_flags;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc;
  int first_cyc;
  bit bp_mode = 1'b0;
  logic [7:0] lfsr = 8'hB7;
  logic [7:0] pkt [7];
  logic [7:0] exp_b [7];

  tdc_report_scheduler #(
    .HB_PERIOD(1000),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .meas_valid  (meas_valid),
    .meas_data   (meas_data),
    .status_flags(status_flags),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk_100m = ~clk_100m;

  // Mirrors the heartbeat timer phase: zero on the last reset edge.
  always @(posedge clk_100m) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic do_reset();
    rst        = 1'b1;
    meas_valid = 1'b0;
    tx_ready   = 1'b0;
    repeat (2) @(negedge clk_100m);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] d);
    meas_valid = 1'b1;
    meas_data  = d;
    @(negedge clk_100m);
    meas_valid = 1'b0;
  endtask

  // Gathers the next seven accepted bytes into pkt, driving tx_ready and
  // checking tx_data/tx_valid stability across stalled cycles.
  task automatic collect(input int budget);
    int n;
    int c;
    bit stalled;
    logic [7:0] held;
    n = 0; c = 0; stalled = 1'b0; held = 8'h00;
    while (n < 7 && c < budget) begin
      @(negedge clk_100m);
      c++;
      if (bp_mode) begin
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        tx_ready = lfsr[0];
      end else begin
        tx_ready = 1'b1;
      end
      if (stalled) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          bad++;
          $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h", tx_valid, tx_data, held);
        end
      end
      stalled = 1'b0;
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          if (n == 0) first_cyc = cyc;
          pkt[n] = tx_data;
          n++;
        end else begin
          stalled = 1'b1;
          held    = tx_data;
        end
      end
    end
    if (n < 7) begin
      total++;
      bad++;
      $display("FAIL collect_timeout got %0d bytes want 7", n);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    meas_valid = 1'b0;
    meas_data  = 32'h0;
    tx_ready   = 1'b0;
    status_flags = 8'h00;
    repeat (2) @(negedge clk_100m);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (drop_count !== 16'h0) begin bad++; $display("FAIL rst_drop got %h want 0000", drop_count); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    tx_ready = 1'b1;
    exp_b = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    pulse(32'h12345678);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid got %b want 0", tx_valid); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_100m);
      total++;
      if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== exp_b[i]) begin
        bad++;
        $display("FAIL single_byte%0d got v=%b b=%b d=%h want v=1 b=1 d=%h", i, tx_valid, busy, tx_data, exp_b[i]);
      end
    end
    @(negedge clk_100m);
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_end got v=%b b=%b want 0 0", tx_valid, busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_mode = 1'b1;
    exp_b = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC8};
    pulse(32'hCAFEF00D);
    collect(300);
    bp_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL bp_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(32'h1);
    @(negedge clk_100m);
    pulse(32'h2);
    @(negedge clk_100m);
    pulse(32'h3);
    @(negedge clk_100m);
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_drop got %h want 0001", drop_count); end
    exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    collect(50);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL ovf_p1_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
    @(negedge clk_100m);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_gap got %b want 0", tx_valid); end
    exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    collect(50);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL ovf_p2_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_drop_end got %h want 0001", drop_count); end
  endtask

  task automatic test_heartbeat();
    do_reset();
    status_flags = 8'h3C;
    exp_b = '{8'hA5, 8'h02, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h3E};
    collect(1200);
    total++; if (first_cyc !== 1001) begin bad++; $display("FAIL hb0_start got %0d want 1001", first_cyc); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL hb0_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
    status_flags = 8'h81;
    exp_b = '{8'hA5, 8'h02, 8'h01, 8'h81, 8'h00, 8'h00, 8'h82};
    collect(1200);
    total++; if (first_cyc !== 2001) begin bad++; $display("FAIL hb1_start got %0d want 2001", first_cyc); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL hb1_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
  endtask

  task automatic test_priority_saturation();
    int w;
    do_reset();
    status_flags = 8'h3C;
    pulse(32'h11);
    @(negedge clk_100m);
    pulse(32'h22);
    @(negedge clk_100m);
    meas_data  = 32'h33;
    meas_valid = 1'b1;
    repeat (3) @(negedge clk_100m);
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL sat_drop3 got %h want 0003", drop_count); end
    repeat (65534) @(negedge clk_100m);
    meas_valid = 1'b0;
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_drop got %h want FFFF", drop_count); end
    w = 0;
    while ((cyc % 1000) != 100 && w < 1100) begin
      @(negedge clk_100m);
      w++;
    end
    exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h10};
    collect(50);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL pri_a_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
    exp_b = '{8'hA5, 8'h02, 8'h00, 8'h3C, 8'hFF, 8'hFF, 8'h3E};
    collect(50);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL pri_hb_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
    exp_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h23};
    collect(50);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL pri_b_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_midpacket();
    bit saw_valid;
    do_reset();
    tx_ready = 1'b1;
    // Three consecutive results: A loads, B is captured while A unloads, C drops.
    meas_valid = 1'b1;
    meas_data  = 32'hAAAA0001;
    @(negedge clk_100m);
    meas_data  = 32'hBBBB0002;
    @(negedge clk_100m);
    meas_data  = 32'hCCCC0003;
    @(negedge clk_100m);
    meas_valid = 1'b0;
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL b2b_drop got %h want 0001", drop_count); end
    repeat (2) @(negedge clk_100m);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin bad++; $display("FAIL mid_byte3 got v=%b d=%h want v=1 d=AA", tx_valid, tx_data); end
    rst = 1'b1;
    @(negedge clk_100m);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    total++; if (drop_count !== 16'h0) begin bad++; $display("FAIL mid_rst_drop got %h want 0000", drop_count); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got %h want 00", tx_data); end
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk_100m);
      if (tx_valid !== 1'b0) saw_valid = 1'b1;
    end
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL mid_no_resume got %b want 0", saw_valid); end
    exp_b = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    pulse(32'hDEADBEEF);
    collect(30);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pkt[i] !== exp_b[i]) begin bad++; $display("FAIL mid_after_byte%0d got %h want %h", i, pkt[i], exp_b[i]); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    meas_valid   = 1'b0;
    meas_data    = 32'h0;
    tx_ready     = 1'b0;
    status_flags = 8'h00;
    @(negedge clk_100m);
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_heartbeat();
    test_priority_saturation();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_report_scheduler.md
# tdc_report_scheduler

Packetizes and schedules everything leaving the design on the single FTDI UART line. It sits between the TDC measurement datapath and the UART byte serializer, all in the 100 MHz PLL domain. It shares the serializer between two requesters: edge-to-edge interval results and a periodic heartbeat/status record. It frames both as fixed-length checksummed packets and counts measurements lost to backpressure.

## Interface
- HB_PERIOD, 100_000_000: clk_100m cycles between heartbeat requests (≥ 16).
- SYNC_BYTE, 8'hA5: first byte of every packet.

- clk_100m  in  1  100 MHz clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- meas_valid  in  1  single-cycle pulse; new interval result on meas_data.
- meas_data  in  32  interval in clk_100m cycles; sampled only when meas_valid=1.
- status_flags  in  8  status snapshot taken at heartbeat packet start.
- tx_data  out  8  byte to serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte when tx_valid & tx_ready.
- drop_count  out  16  measurements lost; saturating.
- busy  out  1  high while a packet is in flight (state SEND).

## Operation
- Holding register: one 32-bit entry plus a hold_full flag.
  - On meas_valid, capture meas_data if hold_full=0 or the entry is being unloaded this cycle.
  - Otherwise drop the result and increment drop_count, saturating at 16'hFFFF.
- Heartbeat timer: counts 0..HB_PERIOD-1 and wraps.
  - At count HB_PERIOD-1, set hb_pending.
  - If hb_pending is already set, the new request merges into it and nothing else happens.
- FSM states: IDLE and SEND, with byte index idx 0..6.
  - In IDLE, if hb_pending=1: load a heartbeat packet, clear hb_pending, go to SEND.
  - Else, if hold_full=1: load a measurement packet, unload the entry (hold_full cleared unless recaptured the same cycle), go to SEND.
  - Else stay in IDLE.
  - Heartbeat has priority over measurement; at most one heartbeat per HB_PERIOD, so measurements cannot starve.
- Packet load copies all 7 bytes into a byte buffer; the packet is immune to later input changes.
- Measurement packet: SYNC_BYTE, 8'h01, meas_data[31:24], [23:16], [15:8], [7:0], CHK.
- Heartbeat packet: SYNC_BYTE, 8'h02, seq, status_flags, drop_count[15:8], drop_count[7:0], CHK.
  - status_flags and drop_count are the values at the load cycle.
  - seq increments 255→0 after each heartbeat load; first heartbeat after reset carries seq=0.
- CHK = XOR of bytes 1 through 5 (type and payload; SYNC excluded).
- SEND: tx_valid=1 and tx_data=byte[idx].
  - idx advances on tx_valid & tx_ready.
  - Acceptance of byte 6 returns the FSM to IDLE, with tx_valid=0 the next cycle.
- tx_data holds stable while tx_valid & !tx_ready; tx_valid never drops mid-packet except on rst.

## Timing
- Reset values (cycle after rst sampled high): state IDLE, tx_valid=0, tx_data=8'h00, busy=0, drop_count=0, seq=0, timer=0, hb_pending=0, hold_full=0.
- Reset mid-packet aborts the packet; the partial packet is never resumed and the buffered measurement is discarded.
- Measurement latency, scheduler idle, tx_ready held 1:
  - meas_valid in cycle t gives hold_full=1 in t+1.
  - The packet loads in t+1; tx_valid=1 with SYNC_BYTE in t+2.
  - Bytes 0..6 occupy t+2..t+8; IDLE in t+9.
- Packets are separated by at least one IDLE cycle.
- Simultaneous capture and unload in the same cycle: the new value is retained, hold_full stays 1, and there is no drop.
- Timer terminal count and packet load in the same cycle: hb_pending is set (for a measurement load) or stays set (for a heartbeat load); the new request is not lost.
- drop_count updates the cycle after the dropped meas_valid.

## Test plan
- Single measurement: HB_PERIOD=1000, meas_data=32'h12345678 pulse, tx_ready=1 → bytes A5 01 12 34 56 78 09; tx_valid first high 2 cycles after the pulse; busy high for 7 cycles.
- Backpressure: tx_ready toggled pseudo-randomly → identical byte sequence; tx_data is stable on every cycle where tx_valid=1 and tx_ready=0.
- Overflow: tx_ready=0, three meas_valid pulses (0x1, 0x2, 0x3) → first is in flight, second is held, third is dropped; drop_count=1; after releasing tx_ready, packets carry 0x1 then 0x2.
- Heartbeat: status_flags=8'h3C, no measurements → after 999 cycles, bytes A5 02 00 3C 00 00 3E; next heartbeat carries seq=01.
- Priority and saturation: heartbeat and measurement pending together → heartbeat first, measurement follows. Forcing 65537 drops gives drop_count=FFFF.
- Reset mid-packet: rst high during byte 3 → tx_valid=0 next cycle, all counters 0; the next measurement produces a complete, correct packet.
